pic_inta_sequencer: RTL and testbench

CPU-side interrupt-acknowledge initiator for the 8259-style PIC. Samples the PIC's `int_req` output, and when interrupts are enabled drives the two-pulse 8086-mode `inta_n` sequence back to the PIC. It captures the vector byte the PIC places on the data bus during the second pulse and hands it to the core over a valid/ack handshake. It sits between the PIC's priority/control logic and the processor's interrupt entry logic.

---
 rtl/pic_inta_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// -----------------------------------------------------------------------------
// pic_inta_sequencer
//
// CPU-side interrupt-acknowledge initiator for an 8259-style PIC (8086 mode).
// Watches the PIC's INT line through a two-flop synchronizer. When interrupts
// are enabled it drives the two-pulse INTA# sequence, then captures the vector
// byte the PIC presents during the second pulse. The vector goes to the core
// over a valid/ack handshake.
//
// Parameters
//   PULSE_CYCLES : clocks inta_n is held low per pulse (1..255)
//   GAP_CYCLES   : clocks inta_n is held high between the pulses (1..255)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous reset, active low
//   int_req    in   1  INT from the PIC (asynchronous, synchronized here)
//   intr_en    in   1  CPU interrupt enable; gates only the start of a sequence
//   data_in    in   8  PIC data bus, sampled at the end of the second pulse
//   inta_n     out  1  registered interrupt-acknowledge strobe, active low
//   busy       out  1  sequence or undelivered vector in progress
//   vector     out  8  captured vector byte
//   spurious   out  1  INT had already dropped when the vector was captured
//   vec_valid  out  1  vector available, held until vec_ack
//   vec_ack    in   1  core accepts the vector (ignored unless vec_valid)
// -----------------------------------------------------------------------------
module pic_inta_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_req,
  input  logic       intr_en,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic       busy,
  output logic [7:0] vector,
  output logic       spurious,
  output logic       vec_valid,
  input  logic       vec_ack
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P1_LOW = 3'd1,
    ST_GAP    = 3'd2,
    ST_P2_LOW = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Counter reload values: the counter runs N-1 down to 0, giving N cycles.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] sync_reg;
  logic       int_sync;
  logic [7:0] vector_reg;
  logic       spurious_reg;
  logic       inta_n_reg, inta_n_next;
  logic       capture;

  assign int_sync = sync_reg[1];

  // Two-flop synchronizer for the asynchronous INT line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], int_req};
    end
  end

  // State register, pulse counter and the registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 8'h00;
      inta_n_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      inta_n_reg <= inta_n_next;
    end
  end

  // Vector capture; values hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector_reg   <= 8'h00;
      spurious_reg <= 1'b0;
    end else if (capture) begin
      vector_reg   <= data_in;
      spurious_reg <= ~int_sync;
    end
  end

  // Next-state logic. Once a sequence has left IDLE, neither int_sync nor
  // intr_en is looked at again until the vector has been delivered.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (int_sync && intr_en) begin
          state_next = ST_P1_LOW;
          cnt_next   = PULSE_LOAD;
        end
      end
      ST_P1_LOW: begin
        if (cnt_reg == 8'h00) begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - 8'h01;
        end
      end
      ST_GAP: begin
        if (cnt_reg == 8'h00) begin
          state_next = ST_P2_LOW;
          cnt_next   = PULSE_LOAD;
        end else begin
          cnt_next = cnt_reg - 8'h01;
        end
      end
      ST_P2_LOW: begin
        if (cnt_reg == 8'h00) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 8'h01;
        end
      end
      ST_DONE: begin
        if (vec_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'h00;
      end
    endcase
  end

  // Output decode. inta_n is precomputed from the next state so the pin is a
  // flop output that is low exactly while the state register sits in a pulse.
  always_comb begin
    capture     = (state_reg == ST_P2_LOW) && (cnt_reg == 8'h00);
    inta_n_next = !((state_next == ST_P1_LOW) || (state_next == ST_P2_LOW));
    busy        = (state_reg != ST_IDLE);
    vec_valid   = (state_reg == ST_DONE);
  end

  assign inta_n   = inta_n_reg;
  assign vector   = vector_reg;
  assign spurious = spurious_reg;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       int_req = 1'b0;
  logic       intr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       vec_ack = 1'b0;

  logic       inta_n_o    [2];
  logic       busy_o      [2];
  logic [7:0] vector_o    [2];
  logic       spurious_o  [2];
  logic       vec_valid_o [2];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Instance 0: default timing. Instance 1: P=4, G=3.
  pic_inta_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .intr_en(intr_en),
    .data_in(data_in), .inta_n(inta_n_o[0]), .busy(busy_o[0]),
    .vector(vector_o[0]), .spurious(spurious_o[0]),
    .vec_valid(vec_valid_o[0]), .vec_ack(vec_ack)
  );

  pic_inta_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .intr_en(intr_en),
    .data_in(data_in), .inta_n(inta_n_o[1]), .busy(busy_o[1]),
    .vector(vector_o[1]), .spurious(spurious_o[1]),
    .vec_valid(vec_valid_o[1]), .vec_ack(vec_ack)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: a sequence is a timeline of 2P+G cycles indexed by
  // m_pos; inta_n is low on the first P and last P positions of that timeline.
  // ---------------------------------------------------------------------------
  int         mp [2] = '{2, 4};
  int         mg [2] = '{1, 3};
  int         m_mode [2] = '{0, 0};   // 0 waiting, 1 acknowledging, 2 holding vector
  int         m_pos  [2] = '{0, 0};
  logic [7:0] m_vec  [2] = '{8'h00, 8'h00};
  logic       m_spur [2] = '{1'b0, 1'b0};
  logic       m_s1 = 1'b0;
  logic       m_s2 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0;
        m_pos[i]  <= 0;
        m_vec[i]  <= 8'h00;
        m_spur[i] <= 1'b0;
      end
      m_s1 <= 1'b0;
      m_s2 <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] == 0) begin
          if (m_s2 && intr_en) begin
            m_mode[i] <= 1;
            m_pos[i]  <= 0;
          end
        end else if (m_mode[i] == 1) begin
          if (m_pos[i] == 2 * mp[i] + mg[i] - 1) begin
            m_vec[i]  <= data_in;
            m_spur[i] <= !m_s2;
            m_mode[i] <= 2;
          end else begin
            m_pos[i] <= m_pos[i] + 1;
          end
        end else begin
          if (vec_ack) m_mode[i] <= 0;
        end
      end
      m_s2 <= m_s1;
      m_s1 <= int_req;
    end
  end

  function automatic logic exp_inta(int i);
    return !(m_mode[i] == 1 && (m_pos[i] < mp[i] || m_pos[i] >= mp[i] + mg[i]));
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    vectors++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT event at %0t", name, $time);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("inta_n[%0d]", i), {7'b0, inta_n_o[i]}, {7'b0, exp_inta(i)});
        chk($sformatf("busy[%0d]", i), {7'b0, busy_o[i]}, {7'b0, m_mode[i] != 0});
        chk($sformatf("vec_valid[%0d]", i), {7'b0, vec_valid_o[i]}, {7'b0, m_mode[i] == 2});
        chk($sformatf("vector[%0d]", i), vector_o[i], m_vec[i]);
        chk($sformatf("spurious[%0d]", i), {7'b0, spurious_o[i]}, {7'b0, m_spur[i]});
      end
    end
  end

  task automatic ticks(int n);
    repeat (n) @(negedge clk);
  endtask

  logic pat_inta [1:9];
  logic pat_vv   [1:9];
  logic got_inta [1:9];
  logic got_vv   [1:9];
  logic [7:0] got_vec8;
  logic       got_spur8;
  bit found;

  initial begin
    pat_inta = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pat_vv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset, then idle with INT low.
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    chk("idle_inta_n", {7'b0, inta_n_o[0]}, 8'h01);
    chk("idle_busy", {7'b0, busy_o[0]}, 8'h00);
    chk("idle_vector", vector_o[0], 8'h00);

    // Default timing, ack tied high, vector 4B.
    intr_en = 1'b1;
    data_in = 8'h4B;
    vec_ack = 1'b1;
    int_req = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      got_inta[e] = inta_n_o[0];
      got_vv[e]   = vec_valid_o[0];
      if (e == 8) begin
        got_vec8  = vector_o[0];
        got_spur8 = spurious_o[0];
      end
    end
    for (int e = 1; e <= 9; e++) begin
      chk($sformatf("pattern_inta_e%0d", e), {7'b0, got_inta[e]}, {7'b0, pat_inta[e]});
      chk($sformatf("pattern_vv_e%0d", e), {7'b0, got_vv[e]}, {7'b0, pat_vv[e]});
    end
    chk("pattern_vector", got_vec8, 8'h4B);
    chk("pattern_spurious", {7'b0, got_spur8}, 8'h00);
    int_req = 1'b0;
    ticks(40);

    // Interrupts disabled: no acknowledge activity, then enable.
    intr_en = 1'b0;
    int_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("disabled_inta0", {7'b0, inta_n_o[0]}, 8'h01);
      chk("disabled_inta1", {7'b0, inta_n_o[1]}, 8'h01);
    end
    intr_en = 1'b1;
    @(negedge clk);
    chk("enable_start0", {7'b0, inta_n_o[0]}, 8'h00);
    chk("enable_start1", {7'b0, inta_n_o[1]}, 8'h00);
    int_req = 1'b0;
    ticks(40);

    // INT drops during the gap: sequence completes and is flagged spurious.
    vec_ack = 1'b0;
    data_in = 8'h4F;
    int_req = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (!inta_n_o[0]) found = 1;
    end
    if (!found) timeout("wait_p1");
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (inta_n_o[0]) found = 1;
    end
    if (!found) timeout("wait_gap");
    int_req = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (vec_valid_o[0]) found = 1;
    end
    if (!found) timeout("wait_valid");
    chk("spur_vector", vector_o[0], 8'h4F);
    chk("spur_flag", {7'b0, spurious_o[0]}, 8'h01);

    // Ack withheld with INT high: vector holds, no new pulses.
    int_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", {7'b0, vec_valid_o[0]}, 8'h01);
      chk("hold_vector", vector_o[0], 8'h4F);
      chk("hold_inta", {7'b0, inta_n_o[0]}, 8'h01);
    end
    vec_ack = 1'b1;
    @(negedge clk);
    chk("ack_idle_valid", {7'b0, vec_valid_o[0]}, 8'h00);
    chk("ack_idle_inta", {7'b0, inta_n_o[0]}, 8'h01);
    @(negedge clk);
    chk("ack_restart_inta", {7'b0, inta_n_o[0]}, 8'h00);
    int_req = 1'b0;
    ticks(40);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) int_req = ~int_req;
      intr_en = ($urandom_range(0, 9) != 0);
      data_in = 8'($urandom);
      vec_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of the first pulse of the P=4 instance.
    int_req = 1'b0;
    vec_ack = 1'b1;
    intr_en = 1'b1;
    ticks(40);
    int_req = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (!inta_n_o[1]) found = 1;
    end
    if (!found) timeout("wait_p1_long");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_inta[%0d]", i), {7'b0, inta_n_o[i]}, 8'h01);
      chk($sformatf("rst_busy[%0d]", i), {7'b0, busy_o[i]}, 8'h00);
      chk($sformatf("rst_valid[%0d]", i), {7'b0, vec_valid_o[i]}, 8'h00);
      chk($sformatf("rst_vector[%0d]", i), vector_o[i], 8'h00);
      chk($sformatf("rst_spur[%0d]", i), {7'b0, spurious_o[i]}, 8'h00);
    end
    ticks(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_e1", {7'b0, inta_n_o[0]}, 8'h01);
    @(negedge clk);
    chk("restart_e2", {7'b0, inta_n_o[0]}, 8'h01);
    @(negedge clk);
    chk("restart_e3", {7'b0, inta_n_o[0]}, 8'h00);
    ticks(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
